// File: rtl/rx_frame_parser.sv
// ---------------------------------------------------------------------------
// rx_frame_parser
//
// Pulls {rx_er, rx_dv, rxd} words from an upstream RX clock-crossing FIFO,
// strips preamble and SFD, and presents the frame bytes on an AXI-Stream
// style master port. The last byte carries m_tlast and an error marker in
// m_tuser (receive error, runt, or truncation at MAX_FRAME_LEN).
//
// The FIFO returns data one cycle after the read strobe. Those words land in
// a 4-entry skid buffer. Reads are issued only while the buffer, including
// any read already in flight, still has room.
//
// Optional feature macro: RX_FRAME_PARSER_STATS_EN enables the saturating
// frame and error counters. When it is undefined, the stat_* outputs are
// tied to zero.
//
// Ports
//   rd_clk          in   1   sole clock, rising edge
//   rd_rst_n        in   1   asynchronous active-low reset
//   fifo_rd_en      out  1   FIFO read strobe
//   fifo_rd_data    in   10  {rx_er, rx_dv, rxd[7:0]}, valid the cycle after a read
//   fifo_rd_empty   in   1   FIFO empty flag
//   m_tdata         out  8   frame byte
//   m_tvalid        out  1   m_tdata valid
//   m_tready        in   1   downstream accept
//   m_tlast         out  1   last byte of frame
//   m_tuser         out  1   frame error marker (meaningful with m_tlast)
//   stat_frame_cnt  out  16  frames delivered
//   stat_err_cnt    out  16  errored frames delivered plus frames dropped
// ---------------------------------------------------------------------------
module rx_frame_parser #(
    parameter int MAX_FRAME_LEN = 1522,
    parameter int MIN_FRAME_LEN = 64
) (
    input  logic        rd_clk,
    input  logic        rd_rst_n,
    output logic        fifo_rd_en,
    input  logic [9:0]  fifo_rd_data,
    input  logic        fifo_rd_empty,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic [15:0] stat_frame_cnt,
    output logic [15:0] stat_err_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_t;

    localparam logic [10:0] MAX_LEN_C  = 11'(MAX_FRAME_LEN);
    localparam logic [10:0] MIN_LEN_C  = 11'(MIN_FRAME_LEN);
    localparam logic [7:0]  PRE_BYTE_C = 8'h55;
    localparam logic [7:0]  SFD_BYTE_C = 8'hD5;

    // Read side and skid buffer
    logic       run_r;
    logic       inflight_r;
    logic [9:0] skid_mem_r [4];
    logic [1:0] skid_wr_ptr_r;
    logic [1:0] skid_rd_ptr_r;
    logic [2:0] skid_cnt_r;
    logic [2:0] occupancy_s;
    logic       push_s;
    logic       pop_s;
    logic       out_free_s;

    // Word at the head of the skid buffer
    logic [9:0] word_s;
    logic       w_er_s;
    logic       w_dv_s;
    logic [7:0] w_byte_s;

    // Frame FSM state
    state_t      state_r;
    logic        sync_r;
    logic [2:0]  pre_cnt_r;
    logic [7:0]  hold_r;
    logic        hold_vld_r;
    logic [10:0] len_r;
    logic        err_r;
    logic        drop_entry_s;

    // run_r keeps the read strobe low while reset is asserted.
    assign occupancy_s = skid_cnt_r + {2'b00, inflight_r};
    assign fifo_rd_en  = run_r & ~fifo_rd_empty & (occupancy_s < 3'd4);
    assign push_s      = inflight_r;
    assign out_free_s  = ~m_tvalid | m_tready;
    // A word is consumed only when the output register could take a beat.
    // This keeps a word from needing to emit while the output is still stalled.
    assign pop_s       = (skid_cnt_r != 3'd0) & out_free_s;

    assign word_s   = skid_mem_r[skid_rd_ptr_r];
    assign w_er_s   = word_s[9];
    assign w_dv_s   = word_s[8];
    assign w_byte_s = word_s[7:0];

    // Read-in-flight tracking and the 4-entry skid buffer
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            run_r         <= 1'b0;
            inflight_r    <= 1'b0;
            skid_wr_ptr_r <= 2'd0;
            skid_rd_ptr_r <= 2'd0;
            skid_cnt_r    <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                skid_mem_r[i] <= 10'd0;
            end
        end else begin
            run_r      <= 1'b1;
            inflight_r <= fifo_rd_en;
            // A read already issued is always captured; room was reserved for it.
            if (push_s) begin
                skid_mem_r[skid_wr_ptr_r] <= fifo_rd_data;
                skid_wr_ptr_r             <= skid_wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                skid_rd_ptr_r <= skid_rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   skid_cnt_r <= skid_cnt_r + 3'd1;
                2'b01:   skid_cnt_r <= skid_cnt_r - 3'd1;
                default: skid_cnt_r <= skid_cnt_r;
            endcase
        end
    end

    // Detects the words that force the FSM into DROP; also feeds the error counter
    always_comb begin
        drop_entry_s = 1'b0;
        if (pop_s && sync_r && w_dv_s) begin
            case (state_r)
                IDLE: drop_entry_s = (w_byte_s != PRE_BYTE_C);
                PREAMBLE: begin
                    if (w_er_s) begin
                        drop_entry_s = 1'b1;
                    end else if (w_byte_s == PRE_BYTE_C) begin
                        // An eighth consecutive 0x55 is not a legal preamble.
                        drop_entry_s = (pre_cnt_r == 3'd7);
                    end else begin
                        drop_entry_s = (w_byte_s != SFD_BYTE_C) || (pre_cnt_r == 3'd0);
                    end
                end
                // The byte at MAX_FRAME_LEN is held, and the frame is still running.
                DATA:    drop_entry_s = hold_vld_r && (len_r == MAX_LEN_C);
                default: drop_entry_s = 1'b0;
            endcase
        end else begin
            drop_entry_s = 1'b0;
        end
    end

    // Frame FSM, lookahead byte, length/error tracking and registered stream outputs
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_r    <= IDLE;
            sync_r     <= 1'b0;
            pre_cnt_r  <= 3'd0;
            hold_r     <= 8'd0;
            hold_vld_r <= 1'b0;
            len_r      <= 11'd0;
            err_r      <= 1'b0;
            m_tvalid   <= 1'b0;
            m_tdata    <= 8'd0;
            m_tlast    <= 1'b0;
            m_tuser    <= 1'b0;
        end else begin
            if (m_tvalid && m_tready) begin
                m_tvalid <= 1'b0;
            end
            if (pop_s) begin
                if (!sync_r) begin
                    // Discard the tail of any frame already running at reset release.
                    if (!w_dv_s) begin
                        sync_r <= 1'b1;
                    end
                end else begin
                    case (state_r)
                        IDLE: begin
                            if (w_dv_s) begin
                                if (drop_entry_s) begin
                                    state_r <= DROP;
                                end else begin
                                    state_r   <= PREAMBLE;
                                    pre_cnt_r <= 3'd1;
                                end
                            end
                        end
                        PREAMBLE: begin
                            if (!w_dv_s) begin
                                state_r <= IDLE;
                            end else if (drop_entry_s) begin
                                state_r <= DROP;
                            end else if (w_byte_s == SFD_BYTE_C) begin
                                state_r    <= DATA;
                                hold_vld_r <= 1'b0;
                                len_r      <= 11'd0;
                                err_r      <= 1'b0;
                            end else begin
                                pre_cnt_r <= pre_cnt_r + 3'd1;
                            end
                        end
                        DATA: begin
                            if (!w_dv_s) begin
                                // End of frame: the held byte is the last one.
                                // With no held byte this was a zero-length frame.
                                if (hold_vld_r) begin
                                    m_tvalid <= 1'b1;
                                    m_tdata  <= hold_r;
                                    m_tlast  <= 1'b1;
                                    m_tuser  <= err_r | (len_r < MIN_LEN_C);
                                end
                                state_r    <= IDLE;
                                hold_vld_r <= 1'b0;
                                len_r      <= 11'd0;
                                err_r      <= 1'b0;
                            end else if (drop_entry_s) begin
                                // Oversize frame: close it on the byte at MAX_FRAME_LEN.
                                m_tvalid   <= 1'b1;
                                m_tdata    <= hold_r;
                                m_tlast    <= 1'b1;
                                m_tuser    <= 1'b1;
                                state_r    <= DROP;
                                hold_vld_r <= 1'b0;
                                len_r      <= 11'd0;
                                err_r      <= 1'b0;
                            end else begin
                                if (hold_vld_r) begin
                                    m_tvalid <= 1'b1;
                                    m_tdata  <= hold_r;
                                    m_tlast  <= 1'b0;
                                    m_tuser  <= 1'b0;
                                end
                                hold_r     <= w_byte_s;
                                hold_vld_r <= 1'b1;
                                len_r      <= len_r + 11'd1;
                                err_r      <= err_r | w_er_s;
                            end
                        end
                        DROP: begin
                            if (!w_dv_s) begin
                                state_r <= IDLE;
                            end
                        end
                        default: state_r <= IDLE;
                    endcase
                end
            end
        end
    end

`ifdef RX_FRAME_PARSER_STATS_EN
    logic        last_xfer_s;
    logic        zlen_err_s;
    logic [1:0]  err_inc_s;
    logic [15:0] frame_cnt_r;
    logic [15:0] err_cnt_r;

    function automatic logic [15:0] sat_add(input logic [15:0] base, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, base} + {15'd0, inc};
        sat_add = sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    assign last_xfer_s = m_tvalid & m_tready & m_tlast;
    assign zlen_err_s  = pop_s & sync_r & (state_r == DATA) & ~w_dv_s & ~hold_vld_r;
    // An errored last beat and a new drop/zero-length event can land in the same cycle.
    assign err_inc_s   = {1'b0, last_xfer_s & m_tuser} + {1'b0, drop_entry_s | zlen_err_s};

    // Saturating frame and error statistics
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            frame_cnt_r <= 16'd0;
            err_cnt_r   <= 16'd0;
        end else begin
            frame_cnt_r <= sat_add(frame_cnt_r, {1'b0, last_xfer_s});
            err_cnt_r   <= sat_add(err_cnt_r, err_inc_s);
        end
    end

    assign stat_frame_cnt = frame_cnt_r;
    assign stat_err_cnt   = err_cnt_r;
`else
    assign stat_frame_cnt = 16'd0;
    assign stat_err_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_rx_frame_parser.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_parser
//
// A FIFO model feeds words to rx_frame_parser. Each frame is described at
// byte level as a preamble list, a payload and per-byte rx_er flags. A frame
// reference model turns that description into the expected beats and the
// expected statistics. A monitor pops those expectations and compares them
// on every accepted beat. It also checks that the outputs stay stable while
// stalled and that the FIFO is never read while empty.
// ---------------------------------------------------------------------------
module tb_rx_frame_parser;

    localparam int MAX_LEN = 1522;
    localparam int MIN_LEN = 64;
`ifdef RX_FRAME_PARSER_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        rd_clk;
    logic        rd_rst_n;
    logic        fifo_rd_en;
    logic [9:0]  fifo_rd_data;
    logic        fifo_rd_empty;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        m_tuser;
    logic [15:0] stat_frame_cnt;
    logic [15:0] stat_err_cnt;

    rx_frame_parser #(
        .MAX_FRAME_LEN (MAX_LEN),
        .MIN_FRAME_LEN (MIN_LEN)
    ) dut (
        .rd_clk         (rd_clk),
        .rd_rst_n       (rd_rst_n),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_rd_empty  (fifo_rd_empty),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .m_tuser        (m_tuser),
        .stat_frame_cnt (stat_frame_cnt),
        .stat_err_cnt   (stat_err_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [9:0] fq[$];      // words waiting in the upstream FIFO
    logic [9:0] exp_q[$];   // expected beats {data, last, user}
    logic [7:0] pre_q[$];
    logic [7:0] pay_q[$];
    bit         er_q[$];

    int exp_frames = 0;
    int exp_errs   = 0;
    int rdy_mode   = 0;     // 0: always ready, 1: ready 1 of 3 cycles, 2: random
    int gap_mode   = 0;     // 1: empty flag pulses randomly
    int cyc        = 0;
    int beat_cnt   = 0;
    int first_cyc  = 0;
    int last_cyc   = 0;

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // FIFO model and ready driver: a read seen before the edge returns data after it.
    initial begin
        bit rd_now;
        fifo_rd_empty = 1'b1;
        fifo_rd_data  = 10'd0;
        m_tready      = 1'b1;
        forever begin
            @(negedge rd_clk);
            rd_now = fifo_rd_en;
            @(posedge rd_clk);
            #1;
            cyc++;
            if (rd_now && fq.size() > 0) begin
                fifo_rd_data = fq.pop_front();
            end
            fifo_rd_empty = (fq.size() == 0) || (gap_mode != 0 && $urandom_range(0, 2) == 0);
            case (rdy_mode)
                1:       m_tready = (cyc % 3 == 0);
                2:       m_tready = ($urandom_range(0, 1) == 1);
                default: m_tready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard comparison, stall stability, empty-read protection
    initial begin
        bit         stall_prev;
        logic [9:0] held;
        logic [9:0] got;
        stall_prev = 1'b0;
        held       = 10'd0;
        forever begin
            @(negedge rd_clk);
            if (rd_rst_n) begin
                if (fifo_rd_en) begin
                    check("rd_when_empty", {63'd0, fifo_rd_empty}, 64'd0);
                end
                got = {m_tdata, m_tlast, m_tuser};
                if (stall_prev) begin
                    check("stall_stable", {53'd0, m_tvalid, got}, {53'd0, 1'b1, held});
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", {54'd0, got}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        check("beat", {54'd0, got}, {54'd0, exp_q.pop_front()});
                    end
                    if (beat_cnt == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    beat_cnt++;
                end
                stall_prev = m_tvalid && !m_tready;
                held       = got;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Reference model: frame rules applied to the byte-level description.
    task automatic send_frame(input int gap_words);
        int k;
        int n;
        int m;
        bit ok;
        bit user;
        bit lst;
        k = 0;
        while (k < pre_q.size() && pre_q[k] == 8'h55) k++;
        ok = (k >= 1) && (k <= 7) && (pre_q.size() == k + 1) && (pre_q[k] == 8'hD5);
        n = pay_q.size();
        if (!ok || n == 0) begin
            exp_errs++;
        end else begin
            if (n > MAX_LEN) begin
                m    = MAX_LEN;
                user = 1'b1;
                exp_errs += 2;       // errored last beat plus the dropped tail
            end else begin
                m    = n;
                user = (n < MIN_LEN);
                foreach (er_q[i]) if (er_q[i]) user = 1'b1;
                if (user) exp_errs++;
            end
            exp_frames++;
            for (int i = 0; i < m; i++) begin
                lst = (i == m - 1);
                exp_q.push_back({pay_q[i], lst, lst & user});
            end
        end
        foreach (pre_q[i]) fq.push_back({1'b0, 1'b1, pre_q[i]});
        foreach (pay_q[i]) fq.push_back({er_q[i], 1'b1, pay_q[i]});
        for (int i = 0; i < gap_words; i++) fq.push_back({2'b00, 8'($urandom_range(0, 255))});
    endtask

    task automatic set_pre(input int k);
        pre_q.delete();
        for (int i = 0; i < k; i++) pre_q.push_back(8'h55);
        pre_q.push_back(8'hD5);
    endtask

    task automatic set_pay_seq(input int n);
        pay_q.delete();
        er_q.delete();
        for (int i = 0; i < n; i++) begin
            pay_q.push_back(8'(i));
            er_q.push_back(1'b0);
        end
    endtask

    task automatic set_pay_rand(input int n, input int er_one_in);
        pay_q.delete();
        er_q.delete();
        for (int i = 0; i < n; i++) begin
            pay_q.push_back(8'($urandom_range(0, 255)));
            er_q.push_back(er_one_in > 0 && $urandom_range(1, er_one_in) == 1);
        end
    endtask

    task automatic wait_drain(input string name);
        int i;
        for (i = 0; i < 9000; i++) begin
            if (fq.size() == 0 && exp_q.size() == 0) break;
            @(posedge rd_clk);
        end
        check(name, {63'd0, (fq.size() == 0 && exp_q.size() == 0)}, 64'd1);
        repeat (16) @(posedge rd_clk);
    endtask

    task automatic check_stats(input string name);
        logic [31:0] exp;
        @(negedge rd_clk);
        exp = STATS_EN ? {16'(exp_frames), 16'(exp_errs)} : 32'd0;
        check(name, {32'd0, stat_frame_cnt, stat_err_cnt}, {32'd0, exp});
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge rd_clk);
        check(name, {27'd0, fifo_rd_en, m_tvalid, m_tdata, m_tlast, m_tuser, stat_frame_cnt, stat_err_cnt}, 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rd_rst_n = 1'b0;
        // Words are pending during reset, so a leaking read strobe would show up.
        for (int i = 0; i < 3; i++) fq.push_back(10'h000);
        repeat (2) @(posedge rd_clk);
        check_reset_outputs("reset_outputs");
        @(posedge rd_clk);
        #2 rd_rst_n = 1'b1;

        // Scenario 1: good 64-byte frame, back-to-back throughput
        set_pre(7); set_pay_seq(64);
        beat_cnt = 0;
        send_frame(3);
        wait_drain("s1_drain");
        check("s1_beats", 64'(beat_cnt), 64'd64);
        check("s1_rate", 64'(last_cyc - first_cyc), 64'd63);
        check_stats("s1_stats");

        // Scenario 2: rx_er on byte 10
        set_pre(7); set_pay_seq(64); er_q[10] = 1'b1;
        send_frame(2);
        wait_drain("s2_drain");
        check_stats("s2_stats");

        // Scenario 3: 40-byte runt; then 63 (runt) and 1-byte frames with a short preamble
        set_pre(7); set_pay_seq(40);
        send_frame(2);
        set_pre(1); set_pay_rand(63, 0);
        send_frame(1);
        set_pre(2); set_pay_rand(1, 0);
        send_frame(1);
        wait_drain("s3_drain");
        check_stats("s3_stats");

        // Scenario 4: 2000-byte frame truncated, next frame intact; then exact MAX_LEN
        set_pre(7); set_pay_rand(2000, 0);
        beat_cnt = 0;
        send_frame(2);
        set_pre(7); set_pay_seq(64);
        send_frame(2);
        wait_drain("s4_drain");
        check("s4_beats", 64'(beat_cnt), 64'(MAX_LEN + 64));
        set_pre(7); set_pay_rand(MAX_LEN, 0);
        send_frame(2);
        wait_drain("s4_max_drain");
        check_stats("s4_stats");

        // Scenario 5: bad preamble, 8x0x55, zero-length frame
        beat_cnt = 0;
        pre_q.delete(); pre_q.push_back(8'h55); pre_q.push_back(8'h55); pre_q.push_back(8'h5D);
        set_pay_rand(30, 0);
        send_frame(2);
        set_pre(8); set_pay_rand(20, 0);
        send_frame(2);
        set_pre(5); set_pay_rand(0, 0);
        send_frame(2);
        wait_drain("s5_drain");
        check("s5_beats", 64'(beat_cnt), 64'd0);
        check_stats("s5_stats");

        // Scenario 6: stalls 2 of 3 cycles, empty flag pulsing
        rdy_mode = 1; gap_mode = 1;
        beat_cnt = 0;
        set_pre(7); set_pay_rand(100, 0);
        send_frame(2);
        wait_drain("s6_drain");
        check("s6_beats", 64'(beat_cnt), 64'd100);
        check_stats("s6_stats");

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            rdy_mode = $urandom_range(0, 2);
            gap_mode = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
                0: set_pre(8);
                1: begin pre_q.delete(); pre_q.push_back(8'h55); pre_q.push_back(8'h5D); end
                2: begin pre_q.delete(); pre_q.push_back(8'hD5); end
                default: set_pre($urandom_range(1, 7));
            endcase
            set_pay_rand($urandom_range(0, 130), 40);
            send_frame($urandom_range(1, 3));
        end
        wait_drain("rand_drain");
        check_stats("rand_stats");

        // Reset mid-frame: no last beat, then resync past the in-progress frame
        rdy_mode = 0; gap_mode = 0;
        beat_cnt = 0;
        set_pre(7); set_pay_rand(300, 0);
        send_frame(2);
        for (int i = 0; i < 2000 && beat_cnt < 50; i++) @(posedge rd_clk);
        check("mid_started", 64'(beat_cnt >= 50), 64'd1);
        @(posedge rd_clk);
        #2 rd_rst_n = 1'b0;
        fq.delete(); exp_q.delete();
        exp_frames = 0; exp_errs = 0;
        check_reset_outputs("mid_reset_outputs");
        fq.push_back({2'b01, 8'h55}); fq.push_back({2'b01, 8'h55}); fq.push_back({2'b01, 8'hD5});
        for (int i = 0; i < 20; i++) fq.push_back({2'b01, 8'($urandom_range(0, 255))});
        fq.push_back(10'h000);
        repeat (2) @(posedge rd_clk);
        #2 rd_rst_n = 1'b1;
        beat_cnt = 0;
        set_pre(7); set_pay_seq(70);
        send_frame(2);
        wait_drain("resync_drain");
        check("resync_beats", 64'(beat_cnt), 64'd70);
        check_stats("resync_stats");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
